amns_host_port: RTL and testbench

AMNS_HOST_PORT -- requirements
Module: amns_host_port

---
 rtl/amns_host_port_pkg.sv | 30 +++
 rtl/amns_host_watchdog.sv | 30 +++
 rtl/amns_host_port.sv | 157 +++++++++++++++
 tb/tb_amns_host_port.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amns_host_port_pkg.sv
// Shared definitions for the AMNS host port: FSM state encoding and the
// BRAM address map (operands first, result block right after them).
package amns_host_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RD_ISSUE,
        RD_CAPT,
        RD_HOLD
    } state_t;

    // Operand area: A (n*s words) followed by B, M and M_prime_0 (n words each).
    function automatic int load_words(input int n, input int s);
        return n * s + 3 * n;
    endfunction

    // The result block starts right after the operand area.
    function automatic int res_base(input int n, input int s);
        return load_words(n, s);
    endfunction

    // The result is one AMNS polynomial: n coefficients of s words.
    function automatic int res_words(input int n, input int s);
        return n * s;
    endfunction

endpackage

// File: rtl/amns_host_watchdog.sv
// Core watchdog for the AMNS host port. Counts consecutive cycles in which the
// port is waiting for the core and flags expiry on the last allowed cycle.
// Only instantiated when AMNS_HOST_TIMEOUT_EN is defined.
module amns_host_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    // Count while running, restart from zero whenever the wait is over.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

    assign o_expired = i_run && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/amns_host_port.sv
// Host-side port of the AMNS multiplier: streams operands into the shared
// BRAM, kicks the core, waits for completion and streams the result back out.
// Optional feature: define AMNS_HOST_TIMEOUT_EN to add a watchdog on the wait
// for core_done_i that raises a sticky error_o and returns to IDLE.
module amns_host_port
    import amns_host_port_pkg::*;
#(
    parameter int WORD_WIDTH     = 17,
    parameter int N              = 5,
    parameter int S              = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          in_valid_i,
    input  logic [WORD_WIDTH-1:0]         in_data_i,
    output logic                          in_ready_o,
    output logic                          out_valid_o,
    output logic [WORD_WIDTH-1:0]         out_data_o,
    input  logic                          out_ready_i,
    output logic                          bram_en_o,
    output logic                          bram_we_o,
    output logic [$clog2(4*N*S+N):0]      bram_addr_o,
    output logic [WORD_WIDTH-1:0]         bram_din_o,
    input  logic [WORD_WIDTH-1:0]         bram_dout_i,
    output logic                          core_start_o,
    input  logic                          core_done_i,
    output logic                          busy_o,
    output logic                          error_o
);

    localparam int AW = $clog2(4*N*S+N) + 1;
    localparam logic [AW-1:0] LAST_LOAD = AW'(load_words(N, S) - 1);
    localparam logic [AW-1:0] RES_START = AW'(res_base(N, S));
    localparam logic [AW-1:0] LAST_RES  = AW'(res_base(N, S) + res_words(N, S) - 1);

    state_t                r_state;
    logic [AW-1:0]         r_addr;
    logic                  r_out_valid;
    logic [WORD_WIDTH-1:0] r_out_data;

    logic w_in_ready;
    logic w_write;
    logic w_read;
    logic w_timeout;

    // Ready is held low while reset is asserted even though the state is IDLE.
    assign w_in_ready = reset_i && ((r_state == IDLE) || (r_state == LOAD));
    assign w_write    = in_valid_i && w_in_ready;
    assign w_read     = (r_state == RD_ISSUE);

`ifdef AMNS_HOST_TIMEOUT_EN
    logic r_error;

    amns_host_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .i_run     ((r_state == WAIT) && !core_done_i),
        .o_expired (w_timeout)
    );

    assign error_o = r_error;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
    assign error_o          = 1'b0;
`endif

    // Main sequencer: load operands, start the core, wait, then drain the result.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef AMNS_HOST_TIMEOUT_EN
            r_error     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_write) begin
                        r_addr  <= AW'(1);
                        r_state <= LOAD;
`ifdef AMNS_HOST_TIMEOUT_EN
                        r_error <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (w_write) begin
                        if (r_addr == LAST_LOAD) begin
                            r_addr  <= '0;
                            r_state <= START;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (core_done_i) begin
                        r_addr  <= RES_START;
                        r_state <= RD_ISSUE;
                    end else if (w_timeout) begin
                        r_addr  <= '0;
                        r_state <= IDLE;
`ifdef AMNS_HOST_TIMEOUT_EN
                        r_error <= 1'b1;
`endif
                    end
                end
                RD_ISSUE: begin
                    r_state <= RD_CAPT;
                end
                RD_CAPT: begin
                    r_out_data  <= bram_dout_i;
                    r_out_valid <= 1'b1;
                    r_state     <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        if (r_addr == LAST_RES) begin
                            r_addr  <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = w_in_ready;
    assign bram_en_o    = w_write || w_read;
    assign bram_we_o    = w_write;
    assign bram_addr_o  = (w_write && (r_state == IDLE)) ? '0 :
                          (w_write || w_read)            ? r_addr : '0;
    assign bram_din_o   = w_write ? in_data_i : '0;
    assign core_start_o = (r_state == START);
    assign busy_o       = (r_state != IDLE);
    assign out_valid_o  = r_out_valid;
    assign out_data_o   = r_out_data;

endmodule

// File: tb/tb_amns_host_port.sv
// Testbench for amns_host_port: BRAM and core models, write/read/result
// scoreboards, reset and stall scenarios. The timeout scenario is compiled
// in when AMNS_HOST_TIMEOUT_EN is defined.
module tb_amns_host_port;

    localparam int WW = 17;
    localparam int N  = 5;
    localparam int S  = 4;
    localparam int AW = $clog2(4*N*S+N) + 1;
    localparam int LW = 35;
    localparam int RB = 35;
    localparam int RW = 20;

    logic          clk = 1'b0;
    logic          rstN = 1'b1;
    logic          inValid = 1'b0;
    logic [WW-1:0] inData = '0;
    logic          inReady;
    logic          outValid;
    logic [WW-1:0] outData;
    logic          outReady = 1'b0;
    logic          bramEn;
    logic          bramWe;
    logic [AW-1:0] bramAddr;
    logic [WW-1:0] bramDin;
    logic [WW-1:0] bramDout = '0;
    logic          coreStart;
    logic          coreDone = 1'b0;
    logic          busy;
    logic          errorFlag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastWrCyc = -10;
    int doneCyc = -10;
    int startCount = 0;
    int nextRd = RB;
    int coreDelay = 10;
    int coreCnt = 0;
    bit firstWord = 1'b0;
    bit prevHold = 1'b0;
    logic [WW-1:0] heldData = '0;

    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    logic [31:0] resQ[$];

    logic [WW-1:0] mem [0:(1<<AW)-1];

    amns_host_port #(
        .WORD_WIDTH     (WW),
        .N              (N),
        .S              (S),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rstN),
        .in_valid_i   (inValid),
        .in_data_i    (inData),
        .in_ready_o   (inReady),
        .out_valid_o  (outValid),
        .out_data_o   (outData),
        .out_ready_i  (outReady),
        .bram_en_o    (bramEn),
        .bram_we_o    (bramWe),
        .bram_addr_o  (bramAddr),
        .bram_din_o   (bramDin),
        .bram_dout_i  (bramDout),
        .core_start_o (coreStart),
        .core_done_i  (coreDone),
        .busy_o       (busy),
        .error_o      (errorFlag)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp events seen by the monitors.
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one-cycle read latency; the result block is preloaded during reset.
    always @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < RW; i++) mem[RB + i] <= WW'(17'h10000 + i);
        end else if (bramEn) begin
            if (bramWe) mem[bramAddr] <= bramDin;
            else        bramDout <= mem[bramAddr];
        end
    end

    // Core model: pulses done coreDelay cycles after start (coreDelay 0 = never).
    always @(posedge clk) begin
        if (!rstN) begin
            coreCnt  <= 0;
            coreDone <= 1'b0;
        end else begin
            coreDone <= (coreCnt == 1);
            if (coreStart && coreDelay > 0) coreCnt <= coreDelay - 1;
            else if (coreCnt > 0)           coreCnt <= coreCnt - 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: checks every BRAM access, the start pulse, latency and the result stream.
    always @(negedge clk) begin
        if (!rstN) begin
            prevHold = 1'b0;
        end else begin
            if (bramEn && bramWe) begin
                lastWrCyc = cyc;
                checkOutput("wr_handshake", {31'd0, inValid && inReady}, 32'd1);
                if (wrAddrQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    checkOutput("wr_addr", 32'(bramAddr), wrAddrQ.pop_front());
                    checkOutput("wr_data", 32'(bramDin), wrDataQ.pop_front());
                end
            end
            if (bramEn && !bramWe) begin
                checkOutput("rd_addr", 32'(bramAddr), 32'(nextRd));
                nextRd++;
            end
            if (coreStart) begin
                startCount++;
                checkOutput("start_after_last_write", 32'(cyc), 32'(lastWrCyc + 1));
            end
            if (coreDone) doneCyc = cyc;
            if (outValid) begin
                if (firstWord) begin
                    firstWord = 1'b0;
                    checkOutput("done_to_valid_latency", 32'(cyc), 32'(doneCyc + 3));
                end
                if (prevHold) checkOutput("hold_stable", 32'(outData), 32'(heldData));
                checkOutput("no_read_in_hold", {31'd0, bramEn}, 32'd0);
                if (outReady) begin
                    prevHold = 1'b0;
                    if (resQ.size() == 0) checkOutput("unexpected_result", 32'd1, 32'd0);
                    else                  checkOutput("result", 32'(outData), resQ.pop_front());
                end else begin
                    prevHold = 1'b1;
                    heldData = outData;
                end
            end else begin
                prevHold = 1'b0;
            end
        end
    end

    // Streams count operand words (data first+i) to addresses 0.., optionally with gaps.
    task automatic applyStimulus(input int count, input int first, input bit gaps);
        for (int i = 0; i < count; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                inValid = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            inValid = 1'b1;
            inData  = WW'(first + i);
            wrAddrQ.push_back(32'(i));
            wrDataQ.push_back(32'(first + i));
            checkOutput("in_ready_load", {31'd0, inReady}, 32'd1);
            @(posedge clk); #1;
        end
        inValid = 1'b0;
    endtask

    // Expected result words for one run, queued when the run is launched.
    task automatic pushResults();
        for (int i = 0; i < RW; i++) resQ.push_back(32'h10000 + i);
        nextRd    = RB;
        firstWord = 1'b1;
    endtask

    // Accepts n result words, optionally stalling on word stallIdx.
    task automatic drainWords(input int n, input int stallIdx, input int stallCycles);
        int k;
        for (int w = 0; w < n; w++) begin
            outReady = 1'b0;
            k = 0;
            while (!outValid && k < 50) begin @(posedge clk); #1; k++; end
            if (!outValid) begin
                checkOutput("out_valid_timeout", 32'd0, 32'd1);
                return;
            end
            if (w == stallIdx) repeat (stallCycles) begin @(posedge clk); #1; end
            outReady = 1'b1;
            @(posedge clk); #1;
            outReady = 1'b0;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, {31'd0, inReady}, 32'd0);
        checkOutput({tag, "_out_valid"}, {31'd0, outValid}, 32'd0);
        checkOutput({tag, "_out_data"}, 32'(outData), 32'd0);
        checkOutput({tag, "_bram_en"}, {31'd0, bramEn}, 32'd0);
        checkOutput({tag, "_bram_we"}, {31'd0, bramWe}, 32'd0);
        checkOutput({tag, "_bram_addr"}, 32'(bramAddr), 32'd0);
        checkOutput({tag, "_bram_din"}, 32'(bramDin), 32'd0);
        checkOutput({tag, "_start"}, {31'd0, coreStart}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_error"}, {31'd0, errorFlag}, 32'd0);
    endtask

    task automatic releaseReset(input string tag);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        wrAddrQ.delete();
        wrDataQ.delete();
        resQ.delete();
        #1;
        checkOutput({tag, "_ready_after_release"}, {31'd0, inReady}, 32'd1);
        checkOutput({tag, "_idle_after_release"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Global safety net so the bench always ends.
    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        // Power-on reset
        #2 rstN = 1'b0;
        #1 checkResetOutputs("por");
        releaseReset("por");

        // Run A: back-to-back load, in_valid ignored while waiting, stall on word 3
        pushResults();
        applyStimulus(LW, 1, 1'b0);
        checkOutput("start_pulse_now", {31'd0, coreStart}, 32'd1);
        @(posedge clk); #1;
        checkOutput("busy_in_wait", {31'd0, busy}, 32'd1);
        checkOutput("start_one_cycle", {31'd0, coreStart}, 32'd0);
        inValid = 1'b1;
        inData  = WW'(17'h1F0F0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("in_ready_wait", {31'd0, inReady}, 32'd0);
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        drainWords(RW, 3, 7);
        checkOutput("runA_all_results", 32'(resQ.size()), 32'd0);
        checkOutput("runA_idle", {31'd0, busy}, 32'd0);
        checkOutput("runA_starts", 32'(startCount), 32'd1);

        // Run B: load with random gaps, no stall
        pushResults();
        applyStimulus(LW, 101, 1'b1);
        drainWords(RW, -1, 0);
        checkOutput("runB_all_results", 32'(resQ.size()), 32'd0);
        checkOutput("runB_starts", 32'(startCount), 32'd2);

        // Reset during load word 12
        applyStimulus(12, 201, 1'b0);
        inValid = 1'b1;
        inData  = WW'(213);
        #2 rstN = 1'b0;
        #1 checkResetOutputs("rst_load");
        inValid = 1'b0;
        releaseReset("rst_load");

        // Full load from address 0 again, then reset during drain word 5
        pushResults();
        applyStimulus(LW, 301, 1'b0);
        drainWords(5, -1, 0);
        begin
            int k = 0;
            while (!outValid && k < 50) begin @(posedge clk); #1; k++; end
            checkOutput("drain5_valid", {31'd0, outValid}, 32'd1);
        end
        checkOutput("drain5_word", 32'(outData), 32'h10005);
        #2 rstN = 1'b0;
        #1 checkResetOutputs("rst_drain");
        releaseReset("rst_drain");
        checkOutput("rst_drain_starts", 32'(startCount), 32'd3);

        // Clean run after the drain reset
        pushResults();
        applyStimulus(LW, 401, 1'b1);
        drainWords(RW, 0, 2);
        checkOutput("runD_all_results", 32'(resQ.size()), 32'd0);
        checkOutput("runD_starts", 32'(startCount), 32'd4);

`ifdef AMNS_HOST_TIMEOUT_EN
        // Watchdog: the core never finishes
        coreDelay = 0;
        applyStimulus(LW, 501, 1'b0);
        repeat (16) begin @(posedge clk); #1; end
        checkOutput("wd_not_yet", {31'd0, errorFlag}, 32'd0);
        checkOutput("wd_still_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        checkOutput("wd_error_set", {31'd0, errorFlag}, 32'd1);
        checkOutput("wd_idle_ready", {31'd0, inReady}, 32'd1);
        checkOutput("wd_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        checkOutput("wd_error_sticky", {31'd0, errorFlag}, 32'd1);
        inValid = 1'b1;
        inData  = WW'(17'h0ABCD);
        wrAddrQ.push_back(32'd0);
        wrDataQ.push_back(32'h0ABCD);
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("wd_error_cleared", {31'd0, errorFlag}, 32'd0);
        checkOutput("wd_reload_busy", {31'd0, busy}, 32'd1);
        rstN = 1'b0;
        #1;
        coreDelay = 10;
        releaseReset("wd_end");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
